k_fifo_2deep_ctrl: RTL and testbench

Two-entry synchronous FIFO built around the team's 2-deep dual-port RAM (`k_dp_2deep_ram_t1`). The block owns the RAM's write-side drive: it generates `wen`, `waddr` and `raddr` from a push/pop interface. It also tracks occupancy, full/empty and misuse errors. It sits between a producer that writes words and a consumer that reads the combinational head-of-queue.

---
 rtl/k_fifo_2deep_ctrl_pkg.sv | 19 +
 rtl/k_fifo_2deep_ctrl_if.sv | 27 ++
 rtl/k_fifo_2deep_ctrl_ram.sv | 23 ++
 rtl/k_fifo_2deep_ctrl.sv | 99 +++++++++
 tb/tb_k_fifo_2deep_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/k_fifo_2deep_ctrl_pkg.sv
// Shared constants, types and helpers for the small FIFO controllers.
package k_fifo_2deep_ctrl_pkg;

   localparam int FIFO_DEPTH = 2;
   localparam int PTR_W      = 2;

   // Bits needed to represent an occupancy from 0 up to and including depth.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int CNT_W = count_width(FIFO_DEPTH);

   typedef struct packed {
      logic ovf;
      logic udf;
   } err_flags_t;

endpackage

// File: rtl/k_fifo_2deep_ctrl_if.sv
// Push/pop bus between a producer/consumer and the 2-deep FIFO controller.
interface k_fifo_2deep_ctrl_if
   import k_fifo_2deep_ctrl_pkg::*;
#(
   parameter int data_size = 8
);
   logic                 clr;
   logic                 push;
   logic [data_size-1:0] din;
   logic                 pop;
   logic [data_size-1:0] dout;
   logic                 full;
   logic                 empty;
   logic [CNT_W-1:0]     count;
   logic                 ovf_err;
   logic                 udf_err;

   modport master (
      output clr, push, din, pop,
      input  dout, full, empty, count, ovf_err, udf_err
   );

   modport slave (
      input  clr, push, din, pop,
      output dout, full, empty, count, ovf_err, udf_err
   );
endinterface

// File: rtl/k_fifo_2deep_ctrl_ram.sv
// Team 2-deep dual-port RAM: registered write port, combinational read port.
module k_dp_2deep_ram_t1 #(
   parameter int data_size = 8,
   parameter int addr_size = 1
) (
   input  logic                 clk,
   input  logic                 wen,
   input  logic [addr_size-1:0] waddr,
   input  logic [data_size-1:0] wdata,
   input  logic [addr_size-1:0] raddr,
   output logic [data_size-1:0] q
);
   logic [data_size-1:0] mem [2**addr_size];

   // Storage array is deliberately not reset; contents survive rst and clr.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   assign q = mem[raddr];
endmodule

// File: rtl/k_fifo_2deep_ctrl.sv
// Two-entry FIFO controller: pointer/flag logic around one 2-deep dual-port RAM.
module k_fifo_2deep_ctrl
   import k_fifo_2deep_ctrl_pkg::*;
#(
   parameter int data_size = 8
) (
   input  logic                clk,
   input  logic                rst,
   k_fifo_2deep_ctrl_if.slave  bus
);
   localparam int addr_size = 1;

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   err_flags_t           err_q, err_d;

   logic                 full;
   logic                 empty;
   logic [PTR_W-1:0]     occupancy;
   logic                 push_ok;
   logic                 pop_ok;
   logic                 wen;
   logic [addr_size-1:0] waddr;
   logic [addr_size-1:0] raddr;
   logic [data_size-1:0] ram_q;

   // Status flags decoded purely from the registered pointers (bit 1 is the wrap bit).
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[0] == rd_ptr_q[0]) && (wr_ptr_q[1] != rd_ptr_q[1]);
      occupancy = wr_ptr_q - rd_ptr_q;
   end

   // Accept/reject decisions and the RAM write-side drive; a full push needs a pop alongside.
   always_comb begin
      push_ok = bus.push && (!full || bus.pop);
      pop_ok  = bus.pop && !empty;
      wen     = push_ok && !bus.clr;
      waddr   = wr_ptr_q[0];
      raddr   = rd_ptr_q[0];
   end

   // Next pointer and sticky error values; flush wins over any push/pop in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q;
      if (bus.clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         err_d    = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (bus.push && full && !bus.pop) begin
            err_d.ovf = 1'b1;
         end
         if (bus.pop && empty) begin
            err_d.udf = 1'b1;
         end
      end
   end

   // Pointer and error registers, cleared immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   k_dp_2deep_ram_t1 #(
      .data_size (data_size),
      .addr_size (addr_size)
   ) u_ram (
      .clk   (clk),
      .wen   (wen),
      .waddr (waddr),
      .wdata (bus.din),
      .raddr (raddr),
      .q     (ram_q)
   );

   assign bus.dout    = ram_q;
   assign bus.full    = full;
   assign bus.empty   = empty;
   assign bus.count   = CNT_W'(occupancy);
   assign bus.ovf_err = err_q.ovf;
   assign bus.udf_err = err_q.udf;
endmodule

// File: tb/tb_k_fifo_2deep_ctrl.sv
// Scoreboard bench for the 2-deep FIFO controller with directed vectors.
module tb_k_fifo_2deep_ctrl;
   logic clk;
   logic rst;

   k_fifo_2deep_ctrl_if #(.data_size(8)) bus ();

   k_fifo_2deep_ctrl #(.data_size(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] modelQ [$];
   logic [7:0] sbQ    [$];
   logic       modelOvf;
   logic       modelUdf;

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: whenever a pop is presented against a non-empty FIFO, the word on dout is consumed.
   always @(negedge clk) begin
      if (!rst && bus.pop && !bus.clr && !bus.empty) begin
         total++;
         if (sbQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL pop_data: got %0h, expected no pop to be accepted at %0t", bus.dout, $time);
         end else begin
            logic [7:0] exp;
            exp = sbQ.pop_front();
            if (bus.dout !== exp) begin
               bad++;
               $display("[TB] FAIL pop_data: got %0h, expected %0h at %0t", bus.dout, exp, $time);
            end
         end
      end
   end

   // Occupancy of 3 can never occur in a two-entry FIFO.
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         assert (bus.count != 2'd3) else begin
            bad++;
            $display("[TB] FAIL count_range: got %0d, expected at most 2 at %0t", bus.count, $time);
         end
      end
   end

   // One clock cycle of stimulus, entered and left at posedge+1; updates the reference model.
   task automatic applyStimulus(input logic p, input logic [7:0] d, input logic po, input logic c);
      logic mFull, mEmpty, pushOk, popOk;
      bus.push = p;
      bus.din  = d;
      bus.pop  = po;
      bus.clr  = c;
      mFull  = (modelQ.size() == 2);
      mEmpty = (modelQ.size() == 0);
      popOk  = po && !mEmpty;
      pushOk = p && (!mFull || po);
      if (!c && popOk) sbQ.push_back(modelQ[0]);
      @(posedge clk);
      #1;
      if (c) begin
         modelQ.delete();
         modelOvf = 1'b0;
         modelUdf = 1'b0;
      end else begin
         if (popOk) void'(modelQ.pop_front());
         if (pushOk) modelQ.push_back(d);
         if (p && mFull && !po) modelOvf = 1'b1;
         if (po && mEmpty) modelUdf = 1'b1;
      end
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.clr  = 1'b0;
   endtask

   task automatic checkOutput(input string name);
      int sz;
      sz = modelQ.size();
      cmp({name, ".empty"}, int'(bus.empty), int'(sz == 0));
      cmp({name, ".full"},  int'(bus.full),  int'(sz == 2));
      cmp({name, ".count"}, int'(bus.count), sz);
      cmp({name, ".ovf"},   int'(bus.ovf_err), int'(modelOvf));
      cmp({name, ".udf"},   int'(bus.udf_err), int'(modelUdf));
      if (sz > 0) cmp({name, ".dout"}, int'(bus.dout), int'(modelQ[0]));
   endtask

   initial begin
      rst      = 1'b1;
      bus.clr  = 1'b0;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.din  = 8'h00;
      modelOvf = 1'b0;
      modelUdf = 1'b0;

      #2;
      checkOutput("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_reset");

      // Fill and drain.
      applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0); checkOutput("fill1");
      applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0); checkOutput("fill2");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("drain1");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("drain2");

      // Wrap through both slots several times.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0); checkOutput("wrap_push");
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);         checkOutput("wrap_pop");
      end

      // Push and pop together while full.
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0); checkOutput("fs_fill1");
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0); checkOutput("fs_fill2");
      applyStimulus(1'b1, 8'h03, 1'b1, 1'b0); checkOutput("fs_both");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("fs_pop1");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("fs_pop2");

      // Push and pop together while holding one word.
      applyStimulus(1'b1, 8'h21, 1'b0, 1'b0); checkOutput("one_fill");
      applyStimulus(1'b1, 8'h22, 1'b1, 1'b0); checkOutput("one_both");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("one_pop");

      // Overflow: contents must survive the rejected push.
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0); checkOutput("ovf_fill1");
      applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0); checkOutput("ovf_fill2");
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0); checkOutput("ovf_push");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("ovf_pop1");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("ovf_pop2");

      // Underflow with a simultaneous push.
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0); checkOutput("udf_push_pop");

      // Flush beats a push in the same cycle and clears both error flags.
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b1); checkOutput("flush");
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0); checkOutput("flush_push");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("flush_pop");

      // Asynchronous reset in mid-cycle with two words held.
      applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0); checkOutput("mid_fill1");
      applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0); checkOutput("mid_fill2");
      #2;
      rst = 1'b1;
      modelQ.delete();
      modelOvf = 1'b0;
      modelUdf = 1'b0;
      #1;
      checkOutput("mid_reset");
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("after_mid_reset");
      applyStimulus(1'b1, 8'hD4, 1'b0, 1'b0); checkOutput("resume_push");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("resume_pop");

      @(posedge clk);
      #1;
      cmp("scoreboard_drained", sbQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
